mem_arbiter: RTL and testbench

Sole owner of the byte-wide main-memory port. Arbitrates between instruction fetch (32-bit word reads) and the load/store buffer (1/2/4-byte loads and stores), and sequences each access as one byte per cycle. Assembles load data little-endian, with sign or zero extension, and returns a one-cycle ready pulse to the requester.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the byte-serial main-memory arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0]  MEM_SIZE_B  = 2'd0;
  localparam logic [1:0]  MEM_SIZE_H  = 2'd1;
  localparam logic [1:0]  MEM_SIZE_W  = 2'd2;
  localparam int unsigned MEM_EXT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_LSB
  } grant_t;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: size_len = 3'd1;
      MEM_SIZE_H: size_len = 3'd2;
      default:    size_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals of the memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_data;

  logic              lsb_valid;
  logic              lsb_way;
  logic [2:0]        lsb_size;
  logic [ADDR_W-1:0] lsb_addr;
  logic [31:0]       lsb_value;
  logic              lsb_ready;
  logic [31:0]       lsb_result;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport master (
    input  if_valid, if_addr, lsb_valid, lsb_way, lsb_size, lsb_addr, lsb_value,
           mem_din, io_buffer_full,
    output if_ready, if_data, lsb_ready, lsb_result, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output if_valid, if_addr, lsb_valid, lsb_way, lsb_size, lsb_addr, lsb_value,
           mem_din, io_buffer_full,
    input  if_ready, if_data, lsb_ready, lsb_result, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between fetch and load/store buffer that owns the
// byte-wide RAM port and sequences every access one byte per cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clear,
  mem_arbiter_if.master bus
);

  state_t            state;
  state_t            state_nxt;
  grant_t            owner;
  grant_t            last_grant;
  logic [ADDR_W-1:0] addr_r;
  logic [2:0]        len_r;
  logic [2:0]        cnt;
  logic [2:0]        cnt_prev;
  logic [1:0]        size_r;
  logic              store_r;
  logic              ext_r;
  logic [31:0]       value_r;
  logic [31:0]       buf_r;
  logic [31:0]       if_data_q;
  logic [31:0]       lsb_result_q;
  logic              wr_q;

  logic              pick_lsb;
  logic              grant;
  logic              stall;
  logic              wr_live;
  logic              if_ready;
  logic              lsb_ready;
  logic [31:0]       load_val;

  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [1:0]  size,
                                         input logic        zext);
    case (size)
      MEM_SIZE_B: extend = {{24{raw[7]  & ~zext}}, raw[7:0]};
      MEM_SIZE_H: extend = {{16{raw[15] & ~zext}}, raw[15:0]};
      default:    extend = raw;
    endcase
  endfunction

  assign pick_lsb = bus.lsb_valid && (!bus.if_valid || last_grant == GNT_IF);
  assign grant    = (bus.if_valid || bus.lsb_valid) && !clear;
  assign stall    = bus.io_buffer_full && (addr_r[17:16] == IO_HI);
  assign cnt_prev = cnt - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant) state_nxt = (pick_lsb && bus.lsb_way) ? ST_WRITE : ST_READ;
      ST_READ: begin
        if (clear)             state_nxt = ST_IDLE;
        else if (cnt == len_r) state_nxt = ST_DONE;
      end
      ST_WRITE: if (!stall && cnt == len_r - 3'd1) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A flush kills a read's pulse even in DONE; a store always reports completion.
  always_comb begin
    wr_live   = (state == ST_WRITE) && !stall;
    if_ready  = (state == ST_DONE) && (owner == GNT_IF) && !clear;
    lsb_ready = (state == ST_DONE) && (owner == GNT_LSB) && (store_r || !clear);
    load_val  = store_r ? '0 : extend(buf_r, size_r, ext_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner        <= GNT_IF;
      last_grant   <= GNT_IF;
      addr_r       <= '0;
      len_r        <= '0;
      cnt          <= '0;
      size_r       <= '0;
      store_r      <= 1'b0;
      ext_r        <= 1'b0;
      value_r      <= '0;
      buf_r        <= '0;
      if_data_q    <= '0;
      lsb_result_q <= '0;
      wr_q         <= 1'b0;
    end else if (rdy) begin
      wr_q <= wr_live;
      case (state)
        ST_IDLE: if (grant) begin
          owner      <= pick_lsb ? GNT_LSB : GNT_IF;
          last_grant <= pick_lsb ? GNT_LSB : GNT_IF;
          addr_r     <= pick_lsb ? bus.lsb_addr : bus.if_addr;
          size_r     <= pick_lsb ? bus.lsb_size[1:0] : MEM_SIZE_W;
          len_r      <= size_len(pick_lsb ? bus.lsb_size[1:0] : MEM_SIZE_W);
          ext_r      <= pick_lsb & bus.lsb_size[MEM_EXT_BIT];
          store_r    <= pick_lsb & bus.lsb_way;
          value_r    <= bus.lsb_value;
          buf_r      <= '0;
          cnt        <= '0;
        end
        // RAM answers one cycle late, so the byte arriving now belongs to cnt-1.
        ST_READ: if (!clear) begin
          if (cnt != 3'd0) buf_r[{cnt_prev[1:0], 3'b000} +: 8] <= bus.mem_din;
          if (cnt != len_r) cnt <= cnt + 3'd1;
        end
        ST_WRITE: if (!stall) cnt <= cnt + 3'd1;
        ST_DONE: begin
          if (if_ready)  if_data_q    <= buf_r;
          if (lsb_ready) lsb_result_q <= load_val;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_a      = addr_r + ADDR_W'(cnt);
  assign bus.mem_dout   = value_r[{cnt[1:0], 3'b000} +: 8];
  assign bus.mem_wr     = rdy ? wr_live : wr_q;
  assign bus.if_ready   = if_ready;
  assign bus.lsb_ready  = lsb_ready;
  assign bus.if_data    = if_ready ? buf_r : if_data_q;
  assign bus.lsb_result = lsb_ready ? load_val : lsb_result_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic clear;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [7:0] ram [0:4095];

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM freezes with the rest of the system when rdy is low.
  always @(posedge clk) begin
    if (rst) begin
      ram[12'h100] <= 8'h13;
      ram[12'h101] <= 8'h05;
      ram[12'h102] <= 8'h00;
      ram[12'h103] <= 8'h00;
      ram[12'h200] <= 8'h80;
    end else if (rdy) begin
      bus.mem_din <= ram[bus.mem_a[11:0]];
      if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic nc();
    cyc();
    look();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.if_valid  = 1'b1; bus.if_addr  = 32'h100;
    bus.lsb_valid = 1'b1; bus.lsb_way  = 1'b0; bus.lsb_size = 3'b000;
    bus.lsb_addr  = 32'h200; bus.lsb_value = 32'h0;
    cyc(); cyc(); look();
    chk("rst_if_ready", bus.if_ready, 1'b0);
    chk("rst_lsb_ready", bus.lsb_ready, 1'b0);
    chk("rst_mem_wr", bus.mem_wr, 1'b0);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_dout", bus.mem_dout, 8'h0);
    chk("rst_if_data", bus.if_data, 32'h0);
    chk("rst_lsb_result", bus.lsb_result, 32'h0);

    // contention from reset: lb at 0x200 first, then word fetch at 0x100
    cyc(); rst = 1'b0; look();
    nc(); chk("cont_lb_a0", bus.mem_a, 32'h200);
    chk("cont_lb_wr", bus.mem_wr, 1'b0);
    nc(); chk("cont_lb_c2_ready", bus.lsb_ready, 1'b0);
    nc(); chk("cont_lb_ready", bus.lsb_ready, 1'b1);
    chk("cont_lb_result", bus.lsb_result, 32'hFFFF_FF80);
    chk("cont_lb_if_quiet", bus.if_ready, 1'b0);
    cyc(); bus.lsb_valid = 1'b0; look();
    chk("cont_gap_if", bus.if_ready, 1'b0);
    chk("cont_gap_lsb", bus.lsb_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      nc(); chk("fetch_mem_a", bus.mem_a, 32'h100 + 32'(k));
    end
    nc(); chk("fetch_c5_ready", bus.if_ready, 1'b0);
    nc(); chk("fetch_ready", bus.if_ready, 1'b1);
    chk("fetch_data", bus.if_data, 32'h0000_0513);
    chk("fetch_lsb_quiet", bus.lsb_ready, 1'b0);
    cyc(); bus.if_valid = 1'b0; look();
    chk("fetch_pulse_end", bus.if_ready, 1'b0);
    chk("fetch_data_hold", bus.if_data, 32'h0000_0513);
    chk("lb_result_hold", bus.lsb_result, 32'hFFFF_FF80);

    // lbu at 0x200
    cyc(); bus.lsb_valid = 1'b1; bus.lsb_way = 1'b0; bus.lsb_size = 3'b100;
    bus.lsb_addr = 32'h200; look();
    nc(); nc(); chk("lbu_c2_ready", bus.lsb_ready, 1'b0);
    nc(); chk("lbu_ready", bus.lsb_ready, 1'b1);
    chk("lbu_result", bus.lsb_result, 32'h0000_0080);
    cyc(); bus.lsb_valid = 1'b0; look();

    // sh 0x1234ABCD at 0x3FF crosses into 0x400
    cyc(); bus.lsb_valid = 1'b1; bus.lsb_way = 1'b1; bus.lsb_size = 3'b001;
    bus.lsb_addr = 32'h3FF; bus.lsb_value = 32'h1234_ABCD; look();
    nc(); chk("sh_wr0", bus.mem_wr, 1'b1);
    chk("sh_a0", bus.mem_a, 32'h3FF);
    chk("sh_d0", bus.mem_dout, 8'hCD);
    nc(); chk("sh_wr1", bus.mem_wr, 1'b1);
    chk("sh_a1", bus.mem_a, 32'h400);
    chk("sh_d1", bus.mem_dout, 8'hAB);
    nc(); chk("sh_ready", bus.lsb_ready, 1'b1);
    chk("sh_result", bus.lsb_result, 32'h0);
    chk("sh_wr_done", bus.mem_wr, 1'b0);
    cyc(); bus.lsb_valid = 1'b0; look();

    // lh back from 0x3FF: sign-extended 0xABCD
    cyc(); bus.lsb_valid = 1'b1; bus.lsb_way = 1'b0; bus.lsb_size = 3'b001;
    bus.lsb_addr = 32'h3FF; look();
    nc(); chk("lh_a0", bus.mem_a, 32'h3FF);
    nc(); chk("lh_a1", bus.mem_a, 32'h400);
    nc(); chk("lh_c3_ready", bus.lsb_ready, 1'b0);
    nc(); chk("lh_ready", bus.lsb_ready, 1'b1);
    chk("lh_result", bus.lsb_result, 32'hFFFF_ABCD);
    cyc(); bus.lsb_valid = 1'b0; look();

    // sb to IO space with the UART FIFO full for three cycles
    cyc(); bus.lsb_valid = 1'b1; bus.lsb_way = 1'b1; bus.lsb_size = 3'b000;
    bus.lsb_addr = 32'h3_0000; bus.lsb_value = 32'h0000_005A; look();
    cyc(); bus.io_buffer_full = 1'b1; look();
    chk("io_stall1", bus.mem_wr, 1'b0);
    nc(); chk("io_stall2", bus.mem_wr, 1'b0);
    nc(); chk("io_stall3", bus.mem_wr, 1'b0);
    chk("io_stall_ready", bus.lsb_ready, 1'b0);
    cyc(); bus.io_buffer_full = 1'b0; look();
    chk("io_wr", bus.mem_wr, 1'b1);
    chk("io_a", bus.mem_a, 32'h3_0000);
    chk("io_d", bus.mem_dout, 8'h5A);
    chk("io_wr_ready", bus.lsb_ready, 1'b0);
    nc(); chk("io_ready", bus.lsb_ready, 1'b1);
    cyc(); bus.lsb_valid = 1'b0; look();

    // flush in cycle 3 of a word fetch, held one more cycle to block a regrant
    cyc(); bus.if_valid = 1'b1; bus.if_addr = 32'h100; look();
    nc(); nc();
    cyc(); clear = 1'b1; look();
    chk("flush_c3_ready", bus.if_ready, 1'b0);
    nc(); chk("flush_state_idle", 32'(dut.state), 32'(ST_IDLE));
    cyc(); clear = 1'b0; bus.if_valid = 1'b0; look();
    chk("flush_no_grant", 32'(dut.state), 32'(ST_IDLE));
    chk("flush_c5_ready", bus.if_ready, 1'b0);
    nc(); chk("flush_c6_ready", bus.if_ready, 1'b0);
    chk("flush_data_hold", bus.if_data, 32'h0000_0513);

    // sw at 0x500 with clear during the write and during DONE
    cyc(); bus.lsb_valid = 1'b1; bus.lsb_way = 1'b1; bus.lsb_size = 3'b010;
    bus.lsb_addr = 32'h500; bus.lsb_value = 32'hDEAD_BEEF; look();
    nc(); chk("sw_a0", bus.mem_a, 32'h500);
    chk("sw_d0", bus.mem_dout, 8'hEF);
    cyc(); clear = 1'b1; look();
    chk("sw_clear_wr", bus.mem_wr, 1'b1);
    chk("sw_a1", bus.mem_a, 32'h501);
    chk("sw_d1", bus.mem_dout, 8'hBE);
    cyc(); clear = 1'b0; look();
    chk("sw_a2", bus.mem_a, 32'h502);
    chk("sw_d2", bus.mem_dout, 8'hAD);
    nc(); chk("sw_wr3", bus.mem_wr, 1'b1);
    chk("sw_a3", bus.mem_a, 32'h503);
    chk("sw_d3", bus.mem_dout, 8'hDE);
    cyc(); clear = 1'b1; look();
    chk("sw_ready", bus.lsb_ready, 1'b1);
    chk("sw_result", bus.lsb_result, 32'h0);
    cyc(); clear = 1'b0; bus.lsb_valid = 1'b0; look();
    chk("sw_pulse_end", bus.lsb_ready, 1'b0);

    // lw back from 0x500 with one rdy-low cycle mid-transfer
    cyc(); bus.lsb_valid = 1'b1; bus.lsb_way = 1'b0; bus.lsb_size = 3'b010;
    bus.lsb_addr = 32'h500; look();
    nc(); chk("lw_a0", bus.mem_a, 32'h500);
    cyc(); rdy = 1'b0; look();
    chk("lw_a1", bus.mem_a, 32'h501);
    cyc(); rdy = 1'b1; look();
    chk("lw_frozen_a1", bus.mem_a, 32'h501);
    nc(); chk("lw_a2", bus.mem_a, 32'h502);
    nc(); chk("lw_a3", bus.mem_a, 32'h503);
    nc(); chk("lw_c6_ready", bus.lsb_ready, 1'b0);
    nc(); chk("lw_ready", bus.lsb_ready, 1'b1);
    chk("lw_result", bus.lsb_result, 32'hDEAD_BEEF);
    cyc(); bus.lsb_valid = 1'b0; look();
    chk("lw_pulse_end", bus.lsb_ready, 1'b0);
    chk("lw_result_hold", bus.lsb_result, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
